// File: rtl/demux1x2.sv
// demux1x2: registered 1-to-2 stream demultiplexer with valid/ready on every side.
// in_sel = 1 steers the input word to output a, in_sel = 0 to output b.
// Each output is a one-entry register that stalls independently of the other.
// Optional feature macro: DEMUX_COUNT_EN adds 16-bit per-output transfer counters.
module demux1x2 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready
`ifdef DEMUX_COUNT_EN
    ,
    output logic [15:0]      a_count,
    output logic [15:0]      b_count
`endif
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]       a_state;
    logic [0:0]       a_state_nxt;
    logic [0:0]       b_state;
    logic [0:0]       b_state_nxt;
    logic [WIDTH-1:0] a_data_nxt;
    logic [WIDTH-1:0] b_data_nxt;
    logic             in_xfer;
    logic             a_load;
    logic             b_load;
    logic             a_xfer;
    logic             b_xfer;

    assign a_valid = (a_state == FULL);
    assign b_valid = (b_state == FULL);

    // Input is accepted when the selected output is empty or draining this cycle.
    always_comb begin
        in_ready = 1'b0;
        if (in_sel) begin
            in_ready = !a_valid || a_ready;
        end else begin
            in_ready = !b_valid || b_ready;
        end
    end

    // Handshake decode: routing is taken from in_sel in the transfer cycle.
    always_comb begin
        in_xfer = in_valid && in_ready;
        a_load  = in_xfer && in_sel;
        b_load  = in_xfer && !in_sel;
        a_xfer  = a_valid && a_ready;
        b_xfer  = b_valid && b_ready;
    end

    // Next-state and next-data for output a; a full slot with a new load stays full.
    always_comb begin
        a_state_nxt = a_state;
        a_data_nxt  = a_data;
        case (a_state)
            EMPTY: begin
                if (a_load) begin
                    a_state_nxt = FULL;
                end
            end
            FULL: begin
                if (a_xfer && !a_load) begin
                    a_state_nxt = EMPTY;
                end
            end
            default: a_state_nxt = EMPTY;
        endcase
        if (a_load) begin
            a_data_nxt = in_data;
        end
    end

    // Next-state and next-data for output b; mirrors output a.
    always_comb begin
        b_state_nxt = b_state;
        b_data_nxt  = b_data;
        case (b_state)
            EMPTY: begin
                if (b_load) begin
                    b_state_nxt = FULL;
                end
            end
            FULL: begin
                if (b_xfer && !b_load) begin
                    b_state_nxt = EMPTY;
                end
            end
            default: b_state_nxt = EMPTY;
        endcase
        if (b_load) begin
            b_data_nxt = in_data;
        end
    end

    // Output registers; reset discards buffered words and clears payloads.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_state <= EMPTY;
            b_state <= EMPTY;
            a_data  <= '0;
            b_data  <= '0;
        end else begin
            a_state <= a_state_nxt;
            b_state <= b_state_nxt;
            a_data  <= a_data_nxt;
            b_data  <= b_data_nxt;
        end
    end

`ifdef DEMUX_COUNT_EN
    logic [15:0] a_count_nxt;
    logic [15:0] b_count_nxt;

    // Per-output transfer counters, wrapping naturally at 16 bits.
    always_comb begin
        a_count_nxt = a_count;
        b_count_nxt = b_count;
        if (a_xfer) begin
            a_count_nxt = a_count + 16'(1);
        end
        if (b_xfer) begin
            b_count_nxt = b_count + 16'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_count <= '0;
            b_count <= '0;
        end else begin
            a_count <= a_count_nxt;
            b_count <= b_count_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_demux1x2.sv
// tb_demux1x2: scoreboard bench for demux1x2 (build with or without DEMUX_COUNT_EN).
module tb_demux1x2;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_data;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] b_data;
    logic             b_valid;
    logic             b_ready;
`ifdef DEMUX_COUNT_EN
    logic [15:0]      a_count;
    logic [15:0]      b_count;
`endif

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    logic [WIDTH-1:0] qa[$];
    logic [WIDTH-1:0] qb[$];
    logic [WIDTH-1:0] mdl_a_data;
    logic [WIDTH-1:0] mdl_b_data;
    logic [15:0]      mdl_a_cnt;
    logic [15:0]      mdl_b_cnt;

    demux1x2 #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready)
`ifdef DEMUX_COUNT_EN
        ,
        .a_count  (a_count),
        .b_count  (b_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: compares DUT state against the model 1 time unit after each
    // negedge, then applies the transfers the coming posedge will perform.
    always @(negedge clk) begin
        logic             exp_ready;
        logic [WIDTH-1:0] exp_word;
        #1;
        if (mon_en) begin
            exp_ready = in_sel ? (qa.size() == 0 || a_ready) : (qb.size() == 0 || b_ready);
            checks++;
            if (in_ready !== exp_ready) begin
                errors++;
                $display("FAIL in_ready: got %b expected %b at %0t", in_ready, exp_ready, $time);
            end
            checks++;
            if (a_valid !== (qa.size() != 0)) begin
                errors++;
                $display("FAIL a_valid: got %b expected %b at %0t", a_valid, qa.size() != 0, $time);
            end
            checks++;
            if (b_valid !== (qb.size() != 0)) begin
                errors++;
                $display("FAIL b_valid: got %b expected %b at %0t", b_valid, qb.size() != 0, $time);
            end
            checks++;
            if (a_data !== mdl_a_data) begin
                errors++;
                $display("FAIL a_data: got %h expected %h at %0t", a_data, mdl_a_data, $time);
            end
            checks++;
            if (b_data !== mdl_b_data) begin
                errors++;
                $display("FAIL b_data: got %h expected %h at %0t", b_data, mdl_b_data, $time);
            end
`ifdef DEMUX_COUNT_EN
            checks++;
            if (a_count !== mdl_a_cnt || b_count !== mdl_b_cnt) begin
                errors++;
                $display("FAIL counts: got a=%h b=%h expected a=%h b=%h at %0t",
                         a_count, b_count, mdl_a_cnt, mdl_b_cnt, $time);
            end
`endif
            if (rst) begin
                qa.delete();
                qb.delete();
                mdl_a_data = '0;
                mdl_b_data = '0;
                mdl_a_cnt  = '0;
                mdl_b_cnt  = '0;
            end else begin
                if (qa.size() != 0 && a_ready) begin
                    exp_word = qa.pop_front();
                    mdl_a_cnt = mdl_a_cnt + 16'(1);
                    checks++;
                    if (a_data !== exp_word) begin
                        errors++;
                        $display("FAIL a_pop: got %h expected %h at %0t", a_data, exp_word, $time);
                    end
                end
                if (qb.size() != 0 && b_ready) begin
                    exp_word = qb.pop_front();
                    mdl_b_cnt = mdl_b_cnt + 16'(1);
                    checks++;
                    if (b_data !== exp_word) begin
                        errors++;
                        $display("FAIL b_pop: got %h expected %h at %0t", b_data, exp_word, $time);
                    end
                end
                if (in_valid && exp_ready) begin
                    if (in_sel) begin
                        qa.push_back(in_data);
                        mdl_a_data = in_data;
                    end else begin
                        qb.push_back(in_data);
                        mdl_b_data = in_data;
                    end
                end
            end
        end
    end

    task automatic drive(input logic r, input logic v, input logic s,
                         input logic [WIDTH-1:0] d, input logic ar, input logic br);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        a_ready  = ar;
        b_ready  = br;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        #2;
        checks++;
        if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got a=%b b=%b expected 0 0", a_valid, b_valid);
        end
        checks++;
        if (a_data !== 8'h00 || b_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: got a=%h b=%h expected 00 00", a_data, b_data);
        end
        mdl_a_data = '0;
        mdl_b_data = '0;
        mdl_a_cnt  = '0;
        mdl_b_cnt  = '0;
        mon_en = 1'b1;
    endtask

    task automatic test_basic_routing();
        drive(1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0);
        #2;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_ready_empty: got %b expected 1", in_ready);
        end
        drive(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        #2;
        checks++;
        if (a_valid !== 1'b1 || a_data !== 8'h5A || b_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_route: got a_valid=%b a_data=%h b_valid=%b expected 1 5a 0",
                     a_valid, a_data, b_valid);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_ready_full: got %b expected 0", in_ready);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
            #2;
            checks++;
            if (a_valid !== 1'b1 || a_data !== 8'h5A) begin
                errors++;
                $display("FAIL stall_hold: got valid=%b data=%h expected 1 5a", a_valid, a_data);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        #2;
        checks++;
        if (a_valid !== 1'b0 || a_data !== 8'h5A) begin
            errors++;
            $display("FAIL stall_drain: got valid=%b data=%h expected 0 5a", a_valid, a_data);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 8; i++) begin
            drive(1'b0, 1'b1, 1'b0, 8'(i), 1'b0, 1'b1);
            #2;
            checks++;
            if (in_ready !== 1'b1 || a_valid !== 1'b0) begin
                errors++;
                $display("FAIL b2b_ready: got in_ready=%b a_valid=%b expected 1 0", in_ready, a_valid);
            end
            if (i > 1) begin
                checks++;
                if (b_valid !== 1'b1 || b_data !== 8'(i - 1)) begin
                    errors++;
                    $display("FAIL b2b_stream: got valid=%b data=%h expected 1 %h",
                             b_valid, b_data, 8'(i - 1));
                end
            end
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        #2;
        checks++;
        if (b_valid !== 1'b1 || b_data !== 8'h08) begin
            errors++;
            $display("FAIL b2b_last: got valid=%b data=%h expected 1 08", b_valid, b_data);
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_independent_stall();
        drive(1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 1'b0, 8'(8'h21 + k), 1'b0, 1'b1);
            #2;
            checks++;
            if (a_valid !== 1'b1 || a_data !== 8'h11) begin
                errors++;
                $display("FAIL indep_a_hold: got valid=%b data=%h expected 1 11", a_valid, a_data);
            end
        end
        drive(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
        #2;
        checks++;
        if (in_ready !== 1'b0 || b_data !== 8'h23) begin
            errors++;
            $display("FAIL indep_sel_a: got in_ready=%b b_data=%h expected 0 23", in_ready, b_data);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b1, 1'b0, 8'h77, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        #2;
        checks++;
        if (a_valid !== 1'b1 || b_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_full: got a=%b b=%b expected 1 1", a_valid, b_valid);
        end
        drive(1'b1, 1'b1, 1'b1, 8'h99, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        #2;
        checks++;
        if (a_valid !== 1'b0 || b_valid !== 1'b0 || a_data !== 8'h00 || b_data !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset: got a=%b/%h b=%b/%h expected 0/00 0/00",
                     a_valid, a_data, b_valid, b_data);
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)),
                  8'($urandom_range(255)), 1'($urandom_range(1)), 1'($urandom_range(1)));
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        end
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL random_drain: got %0d/%0d pending expected 0/0", qa.size(), qb.size());
        end
    endtask

`ifdef DEMUX_COUNT_EN
    task automatic test_count_wrap();
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 65538; i++) begin
            drive(1'b0, 1'b1, 1'b1, 8'(i), 1'b1, 1'b0);
        end
        drive(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
        #2;
        checks++;
        if (a_count !== 16'h0001 || b_count !== 16'h0000) begin
            errors++;
            $display("FAIL count_wrap: got a=%h b=%h expected 0001 0000", a_count, b_count);
        end
    endtask
`endif

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sel   = 1'b0;
        in_data  = '0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        test_reset();
        test_basic_routing();
        test_stall();
        test_back_to_back();
        test_independent_stall();
        test_reset_mid();
        test_random();
`ifdef DEMUX_COUNT_EN
        test_count_wrap();
`endif
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux1x2.md
# demux1x2

Registered 1-to-2 stream demultiplexer with valid/ready handshakes on every side. It is the counterpart of the 2:1 mux used in the datapath: one input stream is steered to output `a` when `in_sel` = 1 and to output `b` when `in_sel` = 0, matching the mux convention `out = sel ? a : b`. Each output owns a one-entry output register, so it can stall independently while full throughput is kept on the other.

## Interface
- `WIDTH`, default 8: data width of input and both outputs.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_data` input WIDTH: input payload.
- `in_sel` input 1: route select; 1 routes to `a`, 0 routes to `b`; sampled only on an input transfer.
- `in_valid` input 1: input payload valid.
- `in_ready` output 1: block accepts the input this cycle.
- `a_data` output WIDTH: output `a` payload, registered.
- `a_valid` output 1: output `a` holds a word.
- `a_ready` input 1: downstream `a` accepts.
- `b_data`, `b_valid`, `b_ready`: same as `a_*`, for output `b`.
- `a_count`, `b_count` output 16 each: transfer counters; present only with `DEMUX_COUNT_EN`.

## Operation
- Input transfer: `in_valid && in_ready` on a rising edge. Output transfer: `x_valid && x_ready`.
- Each output x ∈ {a, b} is a one-entry register with two states, EMPTY (`x_valid`=0) and FULL (`x_valid`=1).
- `in_ready` = `in_sel` ? (!`a_valid` || `a_ready`) : (!`b_valid` || `b_ready`). It is combinational from `in_sel`, `a_valid`/`b_valid` and `a_ready`/`b_ready`. It does not depend on `in_valid`.
- The state transitions for the selected output x are:
  - EMPTY, input transfer: go to FULL and load `in_data`.
  - FULL, output transfer with no input transfer: go to EMPTY.
  - FULL, output transfer and input transfer in the same cycle: stay FULL and load the new word. This is pass-through replacement with no bubble.
  - FULL with `x_ready`=0: hold. `x_data` must stay stable.
- The non-selected output is unaffected by input activity. It still drains on its own `x_ready`.
- `in_sel` may change while the input is stalled. The block routes according to `in_sel` in the cycle the transfer occurs.
- Words are never duplicated, dropped or reordered per output. No ordering is guaranteed between `a` and `b`.
- Data registers load only on an input transfer. Otherwise `x_data` holds its last value, including while `x_valid`=0.

## Timing
- Latency: 1 cycle. A word accepted at edge N is visible on `x_data`/`x_valid` after edge N.
- Throughput: 1 word/cycle sustained into either output while its `x_ready`=1.
- Reset: while `rst`=1 at a rising edge, the following are cleared, overriding any handshake in that cycle:
  - `a_valid`=0, `b_valid`=0.
  - `a_data`=0, `b_data`=0.
  - `a_count`=0, `b_count`=0.
- `in_ready` during reset follows its equation, with the valids cleared. The upstream source must not count transfers while `rst`=1.
- Reset mid-operation discards buffered words without emitting them.
- No combinational path from `in_valid` or `in_data` to any output.

## Configuration
- `DEMUX_COUNT_EN` defined:
  - Adds `a_count` and `b_count`, 16-bit unsigned counters.
  - Each counter increments by 1 on every output transfer of its port.
  - Each counter wraps from 0xFFFF to 0x0000 and clears on reset.
- `DEMUX_COUNT_EN` undefined:
  - The counter ports and logic are absent.
  - All other behaviour is identical.

## Test plan
- Reset and basic routing:
  - Stimulus: reset, then `in_data`=0x5A, `in_sel`=1, `in_valid`=1 for one cycle, with `a_ready`=`b_ready`=0.
  - Response: after the edge, `a_valid`=1, `a_data`=0x5A, `b_valid`=0. `in_ready` for `in_sel`=1 then drops to 0.
- Stall and hold:
  - Stimulus: hold `a_ready`=0 for 5 cycles, then set it to 1.
  - Response: `a_data` stays 0x5A throughout the stall. Exactly one `a` transfer occurs, then `a_valid`=0.
- Back-to-back pass-through:
  - Stimulus: `in_sel`=0 with `b_ready`=1, sending 0x01..0x08 on consecutive cycles.
  - Response: `b` emits 0x01..0x08 in order with no bubbles, `in_ready` stays 1, and `a_valid` stays 0.
- Independent stall:
  - Stimulus: fill `a` with 0x11 and keep `a_ready`=0, then stream 0x21..0x23 with `in_sel`=0 and `b_ready`=1.
  - Response: `b` passes all 3 words, `a` holds 0x11, and `in_ready` is 0 whenever `in_sel`=1.
- Reset mid-operation:
  - Stimulus: both outputs FULL, then assert `rst` for one cycle.
  - Response: `a_valid`=`b_valid`=0 and both data registers are 0. Neither buffered word ever appears.
- `DEMUX_COUNT_EN` counter wrap:
  - Stimulus: 65537 transfers on `a`.
  - Response: `a_count`=0x0001 and `b_count`=0x0000.
